padovan_uart_tx: RTL and testbench

Read-side endpoint of the register-file write port. It monitors the decoded write strobe and Bus C of the Padovan datapath and captures every value written to one selected register. Captured values are queued in a small FIFO and sent to the host as 8N1 UART frames. The ALU/state-machine datapath never stalls: it writes, and this block drains the writes.

---
 rtl/padovan_uart_tx_pkg.sv | 16 +
 rtl/padovan_uart_tx_fifo.sv | 50 +++++
 rtl/padovan_uart_tx.sv | 143 ++++++++++++++
 tb/tb_padovan_uart_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/padovan_uart_tx_pkg.sv
// Shared types for the Padovan register-write UART tap: FSM state encoding
// and the baud divisor derivation.
package padovan_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_t;

  function automatic int calcBaudDiv(input int clkFreq, input int baud);
    return clkFreq / baud;
  endfunction

endpackage

// File: rtl/padovan_uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO. A push at full is accepted only
// when a pop happens on the same edge; a pop on empty is ignored.
module sync_fifo #(
  parameter int DATAWIDTH = 8,
  parameter int FIFODEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATAWIDTH-1:0]         din,
  output logic [DATAWIDTH-1:0]         dout,
  output logic [$clog2(FIFODEPTH):0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(FIFODEPTH);
  localparam int CW = PW + 1;

  logic [DATAWIDTH-1:0] mem [FIFODEPTH];
  logic [PW-1:0]        wrPtr;
  logic [PW-1:0]        rdPtr;
  logic                 pushOk;
  logic                 popOk;

  assign full   = (count == CW'(FIFODEPTH));
  assign empty  = (count == '0);
  assign popOk  = pop && !empty;
  assign pushOk = push && (!full || popOk);
  assign dout   = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk)  rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(pushOk) - CW'(popOk);
    end
  end

  // Storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/padovan_uart_tx.sv
// Captures every Bus C write to one register (active-low strobe), queues it,
// and sends each word as an 8N1 frame; frames run back-to-back while queued.
module padovan_uart_tx
  import padovan_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATAWIDTH = 8,
  parameter int FIFODEPTH = 8,
  parameter int BAUDDIV   = calcBaudDiv(CLK_FREQ, BAUD)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lowWr,
  input  logic [DATAWIDTH-1:0]        DataIn,
  output logic                        sTx,
  output logic                        sBusy,
  output logic                        sDropped,
  output logic [$clog2(FIFODEPTH):0]  sCount
);

  localparam int CW  = $clog2(FIFODEPTH) + 1;
  localparam int BW  = (BAUDDIV > 1) ? $clog2(BAUDDIV) : 1;
  localparam int NW  = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUDDIV - 1);
  localparam logic [NW-1:0] BIT_LAST  = NW'(DATAWIDTH - 1);

  txState_t             state;
  logic [BW-1:0]        baudCnt;
  logic [NW-1:0]        bitCnt;
  logic [DATAWIDTH-1:0] shiftReg;
  logic                 txReg;
  logic                 busyReg;
  logic                 droppedReg;

  logic                 push;
  logic                 fifoPop;
  logic [DATAWIDTH-1:0] fifoDout;
  logic [CW-1:0]        fifoCount;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic                 bitEnd;
  logic                 frameSlot;
  logic                 pushOk;
  logic                 idleNext;
  logic [CW-1:0]        countNext;

  assign push      = ~lowWr;
  assign bitEnd    = (baudCnt == BAUD_LAST);
  // A new frame may start from IDLE, or on the last cycle of a stop bit.
  assign frameSlot = (state == IDLE) || (state == STOP && bitEnd);
  assign fifoPop   = frameSlot && !fifoEmpty;
  assign idleNext  = frameSlot && fifoEmpty;
  assign pushOk    = push && (!fifoFull || fifoPop);
  assign countNext = fifoCount + CW'(pushOk) - CW'(fifoPop);

  sync_fifo #(
    .DATAWIDTH (DATAWIDTH),
    .FIFODEPTH (FIFODEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (fifoPop),
    .din   (DataIn),
    .dout  (fifoDout),
    .count (fifoCount),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baudCnt    <= '0;
      bitCnt     <= '0;
      shiftReg   <= '0;
      txReg      <= 1'b1;
      busyReg    <= 1'b0;
      droppedReg <= 1'b0;
    end else begin
      busyReg <= !idleNext || (countNext != '0);
      if (push && fifoFull && !fifoPop) droppedReg <= 1'b1;
      case (state)
        IDLE: begin
          txReg   <= 1'b1;
          baudCnt <= '0;
          if (!fifoEmpty) begin
            shiftReg <= fifoDout;
            txReg    <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bitEnd) begin
            baudCnt <= '0;
            bitCnt  <= '0;
            txReg   <= shiftReg[0];
            state   <= DATA;
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        DATA: begin
          if (bitEnd) begin
            baudCnt <= '0;
            if (bitCnt == BIT_LAST) begin
              txReg <= 1'b1;
              state <= STOP;
            end else begin
              bitCnt   <= bitCnt + 1'b1;
              shiftReg <= shiftReg >> 1;
              txReg    <= shiftReg[1];
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
        STOP: begin
          if (bitEnd) begin
            baudCnt <= '0;
            if (!fifoEmpty) begin
              shiftReg <= fifoDout;
              txReg    <= 1'b0;
              state    <= START;
            end else begin
              txReg <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baudCnt <= baudCnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign sTx      = txReg;
  assign sBusy    = busyReg;
  assign sDropped = droppedReg;
  assign sCount   = fifoCount;

endmodule

// File: tb/tb_padovan_uart_tx.sv
// Bench for padovan_uart_tx: a cycle-indexed reference built from frame
// timing arithmetic predicts line level, occupancy, busy and drop flag.
module tb_padovan_uart_tx;

  localparam int DIV   = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int FRAME = (DW + 2) * DIV;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lowWr = 1'b1;
  logic [DW-1:0] DataIn = '0;
  logic          sTx;
  logic          sBusy;
  logic          sDropped;
  logic [3:0]    sCount;

  always #5 clk = ~clk;

  padovan_uart_tx #(
    .CLK_FREQ  (50000000),
    .BAUD      (115200),
    .DATAWIDTH (DW),
    .FIFODEPTH (DEPTH),
    .BAUDDIV   (DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .lowWr    (lowWr),
    .DataIn   (DataIn),
    .sTx      (sTx),
    .sBusy    (sBusy),
    .sDropped (sDropped),
    .sCount   (sCount)
  );

  int passCnt = 0;
  int checkCnt = 0;

  // Reference: queue of accepted words, frame start cycle, and the first
  // cycle at which the transmitter may start another frame.
  logic [DW-1:0] exp_q[$];
  int            cyc = 0;
  int            lastPop = -1;
  int            freeCycle = 0;
  logic [DW-1:0] curByte = '0;
  logic          mDropped = 1'b0;

  function automatic logic expTx();
    int o;
    o = cyc - lastPop;
    if (lastPop < 0 || o >= FRAME) return 1'b1;
    if (o < DIV) return 1'b0;
    if (o >= FRAME - DIV) return 1'b1;
    return curByte[o / DIV - 1];
  endfunction

  function automatic logic expBusy();
    return (exp_q.size() != 0) || (cyc < freeCycle);
  endfunction

  function automatic logic [6:0] expAll();
    return {expTx(), expBusy(), mDropped, 4'(exp_q.size())};
  endfunction

  task automatic tick(input logic lw, input logic [DW-1:0] d, input logic r);
    logic popNow;
    @(negedge clk);
    lowWr  = lw;
    DataIn = d;
    rst    = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      exp_q.delete();
      lastPop   = -1;
      freeCycle = 0;
      mDropped  = 1'b0;
    end else begin
      popNow = (exp_q.size() > 0) && (cyc >= freeCycle);
      if (popNow) begin
        curByte   = exp_q.pop_front();
        lastPop   = cyc;
        freeCycle = cyc + FRAME;
      end
      if (!lw) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else mDropped = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, '0, 1'b1);
    tick(1'b1, '0, 1'b1);
    checkCnt++;
    if ({sTx, sBusy, sDropped, sCount} !== 7'b1_0_0_0000)
      $display("FAIL reset tx/busy/drop/cnt got %b expected %b", {sTx, sBusy, sDropped, sCount}, 7'b1_0_0_0000);
    else passCnt++;
  endtask

  task automatic test_single_byte();
    tick(1'b0, 8'h25, 1'b0);
    checkCnt++;
    if (sTx !== 1'b1 || sCount !== 4'd1 || sBusy !== 1'b1)
      $display("FAIL single_capture tx=%b cnt=%0d busy=%b expected tx=1 cnt=1 busy=1", sTx, sCount, sBusy);
    else passCnt++;
    for (int i = 0; i < FRAME + 10; i++) begin
      tick(1'b1, '0, 1'b0);
      checkCnt++;
      if ({sTx, sBusy, sDropped, sCount} !== expAll())
        $display("FAIL single_byte cyc=%0d got %b expected %b", cyc, {sTx, sBusy, sDropped, sCount}, expAll());
      else passCnt++;
    end
    checkCnt++;
    if (sBusy !== 1'b0 || sDropped !== 1'b0)
      $display("FAIL single_end busy=%b drop=%b expected 0 0", sBusy, sDropped);
    else passCnt++;
  endtask

  task automatic test_overflow();
    int peak;
    int n;
    peak = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1'b0, DW'(i), 1'b0);
      if (int'(sCount) > peak) peak = int'(sCount);
      checkCnt++;
      if ({sTx, sBusy, sDropped, sCount} !== expAll())
        $display("FAIL overflow_fill cyc=%0d got %b expected %b", cyc, {sTx, sBusy, sDropped, sCount}, expAll());
      else passCnt++;
    end
    n = 0;
    while (expBusy() && n < 12 * FRAME) begin
      tick(1'b1, '0, 1'b0);
      n++;
      checkCnt++;
      if ({sTx, sBusy, sDropped, sCount} !== expAll())
        $display("FAIL overflow_drain cyc=%0d got %b expected %b", cyc, {sTx, sBusy, sDropped, sCount}, expAll());
      else passCnt++;
    end
    checkCnt++;
    if (peak != DEPTH || sDropped !== 1'b1 || sBusy !== 1'b0)
      $display("FAIL overflow_summary peak=%0d drop=%b busy=%b expected 8 1 0", peak, sDropped, sBusy);
    else passCnt++;
  endtask

  task automatic test_push_pop_full();
    int n;
    tick(1'b1, '0, 1'b1);
    for (int i = 0; i < 9; i++) tick(1'b0, DW'(8'h30 + i), 1'b0);
    checkCnt++;
    if (sCount !== 4'd8 || sDropped !== 1'b0)
      $display("FAIL full_fill cnt=%0d drop=%b expected 8 0", sCount, sDropped);
    else passCnt++;
    n = 0;
    while (cyc + 1 < freeCycle && n < FRAME) begin
      tick(1'b1, '0, 1'b0);
      n++;
    end
    tick(1'b0, 8'hC3, 1'b0);
    checkCnt++;
    if (sCount !== 4'd8 || sDropped !== 1'b0 || sTx !== 1'b0)
      $display("FAIL full_pushpop cnt=%0d drop=%b tx=%b expected 8 0 0", sCount, sDropped, sTx);
    else passCnt++;
    n = 0;
    while (expBusy() && n < 12 * FRAME) begin
      tick(1'b1, '0, 1'b0);
      n++;
      checkCnt++;
      if ({sTx, sBusy, sDropped, sCount} !== expAll())
        $display("FAIL full_drain cyc=%0d got %b expected %b", cyc, {sTx, sBusy, sDropped, sCount}, expAll());
      else passCnt++;
    end
    checkCnt++;
    if (sBusy !== 1'b0)
      $display("FAIL full_drain_timeout busy=%b expected 0", sBusy);
    else passCnt++;
  endtask

  task automatic test_reset_mid_frame();
    int n;
    tick(1'b0, 8'hA5, 1'b0);
    tick(1'b0, 8'h11, 1'b0);
    tick(1'b0, 8'h22, 1'b0);
    n = 0;
    while (cyc - lastPop < DIV + 3 * DIV + 7 && n < FRAME) begin
      tick(1'b1, '0, 1'b0);
      n++;
    end
    checkCnt++;
    if (sCount !== 4'd2 || sTx !== curByte[3])
      $display("FAIL mid_frame_pre cnt=%0d tx=%b expected 2 %b", sCount, sTx, curByte[3]);
    else passCnt++;
    tick(1'b1, '0, 1'b1);
    checkCnt++;
    if ({sTx, sBusy, sDropped, sCount} !== 7'b1_0_0_0000)
      $display("FAIL mid_frame_reset got %b expected %b", {sTx, sBusy, sDropped, sCount}, 7'b1_0_0_0000);
    else passCnt++;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(1'b1, '0, 1'b0);
      checkCnt++;
      if ({sTx, sBusy, sDropped, sCount} !== expAll())
        $display("FAIL mid_frame_after cyc=%0d got %b expected %b", cyc, {sTx, sBusy, sDropped, sCount}, expAll());
      else passCnt++;
    end
  endtask

  task automatic test_idle_line();
    tick(1'b1, '0, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      tick(1'b1, DW'($urandom), 1'b0);
      checkCnt++;
      if ({sTx, sBusy, sDropped, sCount} !== 7'b1_0_0_0000)
        $display("FAIL idle_line cyc=%0d got %b expected %b", cyc, {sTx, sBusy, sDropped, sCount}, 7'b1_0_0_0000);
      else passCnt++;
    end
  endtask

  task automatic test_random();
    int n;
    logic lw;
    tick(1'b1, '0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      // Alternate sparse and bursty phases to hit both idle starts and full.
      if ((i / 500) % 2 == 0) lw = ($urandom_range(0, 199) != 0);
      else lw = ($urandom_range(0, 29) != 0);
      tick(lw, DW'($urandom), 1'b0);
      checkCnt++;
      if ({sTx, sBusy, sDropped, sCount} !== expAll())
        $display("FAIL random cyc=%0d got %b expected %b", cyc, {sTx, sBusy, sDropped, sCount}, expAll());
      else passCnt++;
    end
    n = 0;
    while (expBusy() && n < 12 * FRAME) begin
      tick(1'b1, '0, 1'b0);
      n++;
      checkCnt++;
      if ({sTx, sBusy, sDropped, sCount} !== expAll())
        $display("FAIL random_drain cyc=%0d got %b expected %b", cyc, {sTx, sBusy, sDropped, sCount}, expAll());
      else passCnt++;
    end
    checkCnt++;
    if (sBusy !== 1'b0)
      $display("FAIL random_drain_timeout busy=%b expected 0", sBusy);
    else passCnt++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_overflow();
    test_push_pop_full();
    test_reset_mid_frame();
    test_idle_line();
    test_random();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
